// File: rtl/scnn_layer_shape_sequencer.sv
// Registered per-layer shape sequencer: latches a layer shape, derives ofmap/psum figures with a
// multi-cycle multiply and restoring divide, then counts psum accumulations. Option macro: SCNN_SHAPE_CEIL_DIV_EN.
module scnn_layer_shape_sequencer #(
    parameter int                    MAX_LAYERS      = 8,
    parameter logic [MAX_LAYERS-1:0] LAYER_TYPE_MASK = 8'h03,
    parameter int                    IMG_W           = 10,
    parameter int                    FLT_W           = 3,
    parameter int                    FN_W            = 5,
    parameter int                    MATRIX_ROWS     = 4,
    parameter int                    MAX_FORMER_COL  = 8,
    parameter int                    CG_COLS         = 2,
    parameter int                    PE_COLS         = 3,
    parameter int                    BCAST_CH_TH     = 7,
    parameter int                    BOUND_W         = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IMG_W-1:0]   image_size,
    input  logic [IMG_W-1:0]   image_channels,
    input  logic [FLT_W-1:0]   filter_size,
    input  logic [FN_W-1:0]    filter_numbers,
    input  logic [2:0]         total_layers,
    output logic               info_valid,
    input  logic               info_ready,
    output logic [2:0]         layer_count,
    output logic               conv_flag,
    output logic [IMG_W-1:0]   ofmap_size,
    output logic [5:0]         psum_depth,
    output logic [BOUND_W-1:0] psum_acc_times_bound,
    output logic               cfg_error,
    input  logic               acc_tick,
    output logic               layer_done,
    output logic               all_done
);

    localparam int W2    = 2 * IMG_W;
    localparam int CNT_W = $clog2(W2 + 1);
    localparam logic [W2-1:0]     D_BCAST_L  = W2'(MATRIX_ROWS * CG_COLS * 2 * PE_COLS);
    localparam logic [W2-1:0]     D_UNI_L    = W2'(MATRIX_ROWS * CG_COLS * PE_COLS);
    localparam logic [FN_W-1:0]   MAX_FC_L   = FN_W'(MAX_FORMER_COL);
    localparam logic [IMG_W-1:0]  BCAST_TH_L = IMG_W'(BCAST_CH_TH);
    localparam logic [5:0]        MROWS_L    = 6'(MATRIX_ROWS);
    localparam logic [CNT_W-1:0]  DIV_LAST_L = CNT_W'(W2);
    localparam logic [W2:0]       BOUND_MAX_L = (W2+1)'({BOUND_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_OUT  = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    state_t             state_r;
    logic               cfg_ready_r;
    logic               info_valid_r;
    logic [2:0]         layer_count_r;
    logic [2:0]         total_layers_r;
    logic               conv_flag_r;
    logic [IMG_W-1:0]   ofmap_r;
    logic [5:0]         psum_depth_r;
    logic [BOUND_W-1:0] bound_r;
    logic               cfg_error_r;
    logic               layer_done_r;
    logic               all_done_r;
    logic [W2-1:0]      divisor_r;
    logic [W2-1:0]      dvd_r;
    logic [W2-1:0]      rem_r;
    logic [W2-1:0]      quo_r;
    logic [CNT_W-1:0]   div_cnt_r;
    logic [BOUND_W-1:0] acc_cnt_r;

    logic               hs_s;
    logic               illegal_s;
    logic [IMG_W-1:0]   ofmap_in_s;
    logic [FN_W-1:0]    fn_clamp_s;
    logic [5:0]         psum_depth_in_s;
    logic               conv_in_s;
    logic [W2-1:0]      divisor_in_s;
    logic [W2:0]        rem_shift_s;
    logic [W2:0]        trial_s;
    logic               ge_s;
    logic [W2:0]        q_fin_s;
    logic [BOUND_W-1:0] bound_sat_s;
    logic [BOUND_W-1:0] acc_inc_s;
    logic               run_finish_s;

    // Shape decode for the handshake cycle.
    always_comb begin
        hs_s       = cfg_valid & cfg_ready_r;
        illegal_s  = (filter_size == {FLT_W{1'b0}}) || (IMG_W'(filter_size) > image_size);
        if (illegal_s) begin
            ofmap_in_s = {IMG_W{1'b0}};
        end else begin
            ofmap_in_s = image_size - IMG_W'(filter_size) + IMG_W'(1'b1);
        end
        if (filter_numbers > MAX_FC_L) begin
            fn_clamp_s = MAX_FC_L;
        end else begin
            fn_clamp_s = filter_numbers;
        end
        conv_in_s = LAYER_TYPE_MASK[layer_count_r];
        if (conv_in_s) begin
            psum_depth_in_s = 6'(fn_clamp_s) * MROWS_L;
        end else begin
            psum_depth_in_s = MROWS_L;
        end
        // Few channels: weights broadcast over two CG rows, halving the work per tile.
        if (image_channels < BCAST_TH_L) begin
            divisor_in_s = D_BCAST_L;
        end else begin
            divisor_in_s = D_UNI_L;
        end
    end

    // One restoring-divide step plus the final rounding/saturation of the quotient.
    always_comb begin
        rem_shift_s = {rem_r, dvd_r[W2-1]};
        trial_s     = rem_shift_s - {1'b0, divisor_r};
        ge_s        = ~trial_s[W2];
`ifdef SCNN_SHAPE_CEIL_DIV_EN
        if (rem_r != {W2{1'b0}}) begin
            q_fin_s = {1'b0, quo_r} + (W2+1)'(1'b1);
        end else begin
            q_fin_s = {1'b0, quo_r};
        end
`else
        q_fin_s = {1'b0, quo_r};
`endif
        if (q_fin_s > BOUND_MAX_L) begin
            bound_sat_s = {BOUND_W{1'b1}};
        end else begin
            bound_sat_s = q_fin_s[BOUND_W-1:0];
        end
        acc_inc_s    = acc_cnt_r + BOUND_W'(1'b1);
        run_finish_s = (bound_r == {BOUND_W{1'b0}}) || (acc_tick && (acc_inc_s == bound_r));
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= S_IDLE;
            cfg_ready_r    <= 1'b1;
            info_valid_r   <= 1'b0;
            layer_count_r  <= 3'd0;
            total_layers_r <= 3'd0;
            conv_flag_r    <= 1'b0;
            ofmap_r        <= {IMG_W{1'b0}};
            psum_depth_r   <= 6'd0;
            bound_r        <= {BOUND_W{1'b0}};
            cfg_error_r    <= 1'b0;
            layer_done_r   <= 1'b0;
            all_done_r     <= 1'b0;
            divisor_r      <= {W2{1'b0}};
            dvd_r          <= {W2{1'b0}};
            rem_r          <= {W2{1'b0}};
            quo_r          <= {W2{1'b0}};
            div_cnt_r      <= {CNT_W{1'b0}};
            acc_cnt_r      <= {BOUND_W{1'b0}};
        end else begin
            layer_done_r <= 1'b0;
            all_done_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (hs_s) begin
                        cfg_ready_r    <= 1'b0;
                        cfg_error_r    <= illegal_s;
                        ofmap_r        <= ofmap_in_s;
                        psum_depth_r   <= psum_depth_in_s;
                        conv_flag_r    <= conv_in_s;
                        divisor_r      <= divisor_in_s;
                        total_layers_r <= total_layers;
                        state_r        <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (cfg_error_r) begin
                        bound_r      <= {BOUND_W{1'b0}};
                        info_valid_r <= 1'b1;
                        state_r      <= S_OUT;
                    end else begin
                        dvd_r     <= W2'(ofmap_r) * W2'(ofmap_r);
                        rem_r     <= {W2{1'b0}};
                        quo_r     <= {W2{1'b0}};
                        div_cnt_r <= {CNT_W{1'b0}};
                        state_r   <= S_DIV;
                    end
                end
                S_DIV: begin
                    // W2 quotient-bit steps, then one finalize cycle.
                    if (div_cnt_r == DIV_LAST_L) begin
                        bound_r      <= bound_sat_s;
                        info_valid_r <= 1'b1;
                        state_r      <= S_OUT;
                    end else begin
                        rem_r     <= ge_s ? trial_s[W2-1:0] : rem_shift_s[W2-1:0];
                        quo_r     <= {quo_r[W2-2:0], ge_s};
                        dvd_r     <= {dvd_r[W2-2:0], 1'b0};
                        div_cnt_r <= div_cnt_r + CNT_W'(1'b1);
                    end
                end
                S_OUT: begin
                    if (info_ready) begin
                        info_valid_r <= 1'b0;
                        acc_cnt_r    <= {BOUND_W{1'b0}};
                        state_r      <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_finish_s) begin
                        layer_done_r <= 1'b1;
                        acc_cnt_r    <= {BOUND_W{1'b0}};
                        cfg_ready_r  <= 1'b1;
                        state_r      <= S_IDLE;
                        if (layer_count_r == total_layers_r) begin
                            all_done_r    <= 1'b1;
                            layer_count_r <= 3'd0;
                        end else begin
                            layer_count_r <= layer_count_r + 3'd1;
                        end
                    end else if (acc_tick) begin
                        acc_cnt_r <= acc_inc_s;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    cfg_ready_r  <= 1'b1;
                    info_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready            = cfg_ready_r;
    assign info_valid           = info_valid_r;
    assign layer_count          = layer_count_r;
    assign conv_flag            = conv_flag_r;
    assign ofmap_size           = ofmap_r;
    assign psum_depth           = psum_depth_r;
    assign psum_acc_times_bound = bound_r;
    assign cfg_error            = cfg_error_r;
    assign layer_done           = layer_done_r;
    assign all_done             = all_done_r;

endmodule
